// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM type and feedback helpers shared by lfsr_gen and lfsr_step.
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} lfsr_fsm_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] lockup_value(input int width, input bit xnor_mode);
    return xnor_mode ? ({MAX_W{1'b1}} >> (MAX_W - width)) : '0;
  endfunction
  function automatic logic feedback(input logic [MAX_W-1:0] state, input logic [MAX_W-1:0] taps, input bit xnor_mode);
    return (^(state & taps)) ^ xnor_mode;
  endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational Fibonacci next state and feedback bit.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(32'h8000_8000),
  parameter bit               XNOR_MODE = 1'b1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o,
  output logic             fb_o
);
  assign fb_o   = feedback(MAX_W'(state_i), MAX_W'(TAPS), XNOR_MODE);
  assign next_o = {state_i[WIDTH-2:0], fb_o};
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR word generator with handshake and period measurement.
// Define LFSR_LOCKUP_EN to replace lock-up seed loads with RESET_SEED.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(32'h8000_8000),
  parameter bit               XNOR_MODE  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_SEED = '0,
  parameter int               OUT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state_q,
  output logic [OUT_W-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);
  localparam int BW = $clog2(OUT_W + 1);
  lfsr_fsm_t        fsm;
  logic [WIDTH-1:0] nxt, seed_eff, seed_q, seed_d, state_d, pcnt_q, pcnt_d, period_q, period_d;
  logic [OUT_W-1:0] sh_q, sh_d, word_q, word_d, shifted;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             fb, step, done, hit, valid_q, valid_d, wrap_q, wrap_d;
  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .XNOR_MODE(XNOR_MODE)) u_step (
    .state_i(state_q),
    .next_o (nxt),
    .fb_o   (fb)
  );
`ifdef LFSR_LOCKUP_EN
  localparam logic [WIDTH-1:0] LOCK = WIDTH'(lockup_value(WIDTH, XNOR_MODE));
  logic lock_hit, lockup_q;
  assign lock_hit = seed == LOCK;
  assign seed_eff = lock_hit ? RESET_SEED : seed;
  always_ff @(posedge clk or posedge reset)
    if (reset) lockup_q <= 1'b0;
    else       lockup_q <= load && lock_hit;
  assign lockup = lockup_q;
`else
  assign seed_eff = seed;
  assign lockup   = 1'b0;
`endif
  always_comb begin
    fsm      = (valid_q && !out_ready) ? HOLD : enable ? RUN : IDLE;
    step     = (fsm == RUN) && !load;
    done     = step && (bcnt_q == BW'(OUT_W - 1));
    hit      = nxt == seed_q;
    shifted  = OUT_W'({sh_q, fb});
    state_d  = load ? seed_eff : step ? nxt : state_q;
    seed_d   = load ? seed_eff : seed_q;
    sh_d     = load ? '0 : step ? shifted : sh_q;
    bcnt_d   = (load || done) ? '0 : step ? bcnt_q + 1'b1 : bcnt_q;
    word_d   = done ? shifted : word_q;
    valid_d  = !load && (done || (valid_q && !out_ready));
    pcnt_d   = load ? '0 : step ? (hit ? '0 : pcnt_q + 1'b1) : pcnt_q;
    period_d = (step && hit) ? pcnt_q + 1'b1 : period_q;
    wrap_d   = step && hit;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= RESET_SEED;
      seed_q   <= RESET_SEED;
      sh_q     <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      sh_q     <= sh_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
  assign period    = period_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: default 32-bit instance plus a 4-bit XOR instance checked by table, sequences and a model.
module tb_lfsr_gen;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, load = 1'b0, out_ready = 1'b1;
  logic [31:0] seed_a = '0, state_a, period_a;
  logic [15:0] word_a;
  logic        valid_a, wrap_a, lock_a;
  logic [3:0]  seed_b = '0, state_b, word_b, period_b;
  logic        valid_b, wrap_b, lock_b;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  lfsr_gen u_a (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed(seed_a),
    .state_q(state_a), .out_word(word_a), .out_valid(valid_a), .out_ready(out_ready),
    .wrap(wrap_a), .period(period_a), .lockup(lock_a)
  );
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .XNOR_MODE(1'b0), .RESET_SEED(4'h1), .OUT_W(4)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed(seed_b),
    .state_q(state_b), .out_word(word_b), .out_valid(valid_b), .out_ready(out_ready),
    .wrap(wrap_b), .period(period_b), .lockup(lock_b)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference model of the 4-bit instance: integer arithmetic and a bit queue
  logic [3:0] m_state, m_seed, m_word, m_period;
  int         m_pcnt;
  bit         m_valid, m_wrap, m_lock;
  bit         bits[$];
  task automatic model_reset();
    m_state = 4'h1; m_seed = 4'h1; m_word = '0; m_period = '0;
    m_pcnt = 0; m_valid = 0; m_wrap = 0; m_lock = 0;
    bits.delete();
  endtask
  task automatic model_step(input bit en, input bit ld, input logic [3:0] sd, input bit rdy);
    int s, fb, w;
    m_wrap = 0;
    m_lock = 0;
    if (ld) begin
      m_state = sd;
`ifdef LFSR_LOCKUP_EN
      if (sd == 4'h0) begin
        m_state = 4'h1;
        m_lock  = 1;
      end
`endif
      m_seed = m_state; m_valid = 0; m_pcnt = 0;
      bits.delete();
    end else begin
      bit stall;
      stall = m_valid && !rdy;
      if (m_valid && rdy) m_valid = 0;
      if (en && !stall) begin
        fb = $countones(m_state & 4'hC) % 2;
        s = (int'(m_state) * 2 + fb) % 16;
        m_state = 4'(s);
        bits.push_back(fb[0]);
        if (bits.size() == 4) begin
          w = 0;
          foreach (bits[i]) w = w * 2 + int'(bits[i]);
          m_word = 4'(w);
          m_valid = 1;
          bits.delete();
        end
        m_pcnt = (m_pcnt + 1) % 16;
        if (m_state == m_seed) begin
          m_wrap = 1;
          m_period = 4'(m_pcnt);
          m_pcnt = 0;
        end
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1; enable = 0; load = 0; out_ready = 1; seed_b = '0;
    @(negedge clk);
    reset = 0;
  endtask
  typedef struct {
    bit en; bit ld; logic [3:0] sd; bit rdy; int cyc;
    logic [3:0] st; bit vld; logic [3:0] wd;
  } vec_t;
  vec_t tbl[6];
  initial begin
    tbl[0] = '{1, 0, 4'h0, 1, 4,  4'h3, 1, 4'h3};
    tbl[1] = '{1, 0, 4'h0, 0, 10, 4'h3, 1, 4'h3};
    tbl[2] = '{1, 0, 4'h0, 1, 1,  4'h6, 0, 4'h3};
    tbl[3] = '{0, 0, 4'h0, 1, 3,  4'h6, 0, 4'h3};
    tbl[4] = '{0, 1, 4'h5, 1, 1,  4'h5, 0, 4'h3};
    tbl[5] = '{1, 0, 4'h0, 1, 4,  4'hE, 1, 4'hE};
    // reset state
    @(negedge clk);
    chk("rst_state_a", state_a, 32'h0);
    chk("rst_state_b", state_b, 4'h1);
    chk("rst_valid", valid_b, 0);
    chk("rst_word", word_b, 0);
    chk("rst_wrap", wrap_b, 0);
    chk("rst_period", period_b, 0);
    chk("rst_lockup", lock_b, 0);
    reset = 0;
    // default instance: XNOR feedback from an all-zero seed shifts in ones
    enable = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("a_state4", state_a, 32'h0000_000F);
    chk("a_valid4", valid_a, 0);
    chk("b_state4", state_b, 4'h3);
    // table of multi-row scenarios on the 4-bit instance
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enable = tbl[i].en; load = tbl[i].ld; seed_b = tbl[i].sd; out_ready = tbl[i].rdy;
      repeat (tbl[i].cyc) @(posedge clk);
      @(negedge clk);
      load = 0;
      chk($sformatf("tbl%0d_state", i), state_b, tbl[i].st);
      chk($sformatf("tbl%0d_valid", i), valid_b, tbl[i].vld);
      chk($sformatf("tbl%0d_word", i), word_b, tbl[i].wd);
    end
    // period measurement over the full 15-state sequence
    do_reset();
    enable = 1;
    begin
      int n = 0;
      for (int k = 1; k <= 40 && n == 0; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (wrap_b) n = k;
      end
      chk("wrap_step", n, 15);
      chk("period15", period_b, 4'hF);
      chk("state_at_wrap", state_b, 4'h1);
      @(posedge clk);
      @(negedge clk);
      chk("wrap_one_cycle", wrap_b, 0);
    end
    // lock-up seed load
    do_reset();
    load = 1; seed_b = 4'h0;
    @(posedge clk);
    @(negedge clk);
    load = 0;
`ifdef LFSR_LOCKUP_EN
    chk("lk_state", state_b, 4'h1);
    chk("lk_pulse", lock_b, 1);
    @(posedge clk);
    @(negedge clk);
    chk("lk_pulse_end", lock_b, 0);
    chk("lk_state_hold", state_b, 4'h1);
`else
    chk("lk_state", state_b, 4'h0);
    chk("lk_pulse", lock_b, 0);
    enable = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lk_stuck", state_b, 4'h0);
    chk("lk_wrap", wrap_b, 1);
    chk("lk_period", period_b, 4'h1);
`endif
    // asynchronous reset in the middle of a word
    do_reset();
    enable = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ar_state_mid", state_b, 4'h4);
    #2 reset = 1;
    #1;
    chk("ar_state", state_b, 4'h1);
    chk("ar_valid", valid_b, 0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ar_valid3", valid_b, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ar_valid4", valid_b, 1);
    chk("ar_word4", word_b, 4'h3);
    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      chk("rnd_state", state_b, m_state);
      chk("rnd_valid", valid_b, m_valid);
      chk("rnd_word", word_b, m_word);
      chk("rnd_wrap", wrap_b, m_wrap);
      chk("rnd_period", period_b, m_period);
      chk("rnd_lockup", lock_b, m_lock);
      enable    = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      load      = $urandom_range(0, 19) == 0;
      seed_b    = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_step(enable, load, seed_b, out_ready);
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random word generator; the next generation of the team's fixed 32-bit XNOR LFSR. Adds configurable width and tap mask, XOR/XNOR mode, runtime seed load, and packing of feedback bits into OUT_W-bit words behind a valid/ready handshake. Also measures the sequence period and optionally recovers from the lock-up state. It sits between control logic and any consumer of test patterns or noise words.

## Interface
- WIDTH, 32: LFSR length, 3..64.
- TAPS, 32'h8000_8000: feedback tap mask, WIDTH bits; bit i set means state[i] feeds back.
- XNOR_MODE, 1: 1 selects XNOR feedback, 0 selects XOR.
- RESET_SEED, 0: state after reset; must not equal the lock-up value.
- OUT_W, 16: output word width, 1..WIDTH.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; steps only when high and not stalled.
- load  in  1  one-cycle seed load strobe.
- seed  in  WIDTH  value taken on load.
- state_q  out  WIDTH  current LFSR state.
- out_word  out  OUT_W  packed feedback bits; first generated bit is the MSB.
- out_valid  out  1  out_word holds an unconsumed word.
- out_ready  in  1  consumer accepts out_word.
- wrap  out  1  one-cycle pulse when the state returns to the last loaded or reset seed.
- period  out  WIDTH  step count of the most recent completed cycle.
- lockup  out  1  one-cycle pulse when a lock-up seed load is corrected.

## Operation
- Feedback: fb = ^(state & TAPS), inverted when XNOR_MODE=1. Next state is {state[WIDTH-2:0], fb}.
- Lock-up value: all ones in XNOR mode, all zeros in XOR mode.
- FSM states:
  - IDLE: enable=0.
  - RUN: enable=1 and not stalled; a step occurs.
  - HOLD: out_valid=1 and out_ready=0; no step, regardless of enable.
- Packing:
  - Each step shifts fb into pack register sh and increments bit counter bcnt.
  - When bcnt reaches OUT_W-1: out_word <= {sh[OUT_W-2:0], fb}, out_valid <= 1, bcnt <= 0.
- Handshake:
  - A word transfers when out_valid && out_ready.
  - out_valid clears on transfer unless a new word completes in the same cycle; it then stays 1 with the new word.
  - out_word is stable while in HOLD.
- Load:
  - Sets state <= seed and seed_q <= seed.
  - Clears sh, bcnt, out_valid and the step counter. Does not change period.
  - load takes priority over a step and over a transfer in the same cycle.
- Period measurement:
  - Step counter pcnt (WIDTH bits) increments on each step.
  - When the next state equals seed_q: wrap pulses, period <= pcnt+1, pcnt <= 0.
  - pcnt wraps modulo 2^WIDTH without flagging.

## Timing
- Reset values:
  - state_q = RESET_SEED, seed_q = RESET_SEED.
  - out_word = 0, out_valid = 0, wrap = 0, period = 0, lockup = 0.
  - FSM = IDLE, bcnt = 0, pcnt = 0.
- A step in cycle n is visible on state_q in cycle n+1.
- out_valid rises in the cycle after the OUT_W-th step; the minimum word interval is OUT_W cycles.
- wrap and lockup are registered and last exactly one cycle.
- Reset mid-word discards the partial word. Reset mid-HOLD drops the held word.

## Configuration
- Macro: LFSR_LOCKUP_EN.
- Defined: a load whose seed equals the lock-up value loads RESET_SEED instead, into both state and seed_q, and pulses lockup.
- Undefined: seed is loaded verbatim. The LFSR then sticks at the lock-up value, wrap pulses every step with period=1, and lockup is tied to 0.

## Structure
- Package lfsr_pkg:
  - FSM enum typedef (IDLE/RUN/HOLD).
  - function lockup_value(width, xnor_mode).
  - function feedback(state, taps, xnor_mode).
- Sub-module lfsr_step: combinational next-state and fb from state, TAPS and XNOR_MODE; instantiated once.

## Test plan
- Defaults, reset, then enable=1, out_ready=1 for 4 cycles -> state_q = 32'h0000_000F; out_valid=0.
- WIDTH=4, TAPS=4'b1100, XOR, RESET_SEED=4'h1, OUT_W=4; enable 4 cycles -> out_word=4'h3, out_valid=1; state_q=4'h3.
- Same configuration, run 15 steps -> wrap pulses on the 15th step; period=15.
- Same configuration, out_ready=0 after the first word -> HOLD; state_q frozen at 4'h3 for 10 cycles; out_ready=1 -> transfer, then stepping resumes.
- Same configuration, load with seed=4'h0 -> with LFSR_LOCKUP_EN: state_q=4'h1, lockup pulse; without it: state_q=4'h0 stuck, period=1.
- Assert reset asynchronously mid-word (bcnt=2) -> immediately state_q=RESET_SEED, out_valid=0; the next word needs a full OUT_W steps.
